// File: rtl/scan_sequencer.sv
// Scan sequencer: sweeps a 3-bit decoder select 0..7, holding each value for a
// programmable dwell, in one-shot or continuous mode. All outputs are registered.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [DWELL_W-1:0] DW_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_eff;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= DW_ZERO;
      dwell_q <= DW_ZERO;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    cont_d    = cont_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    // A zero dwell is promoted to one so every select is shown at least once
    dwell_eff = (dwell == DW_ZERO) ? DW_ONE : dwell;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SCAN;
          cont_d  = cont;
          dwell_d = dwell_eff;
          cnt_d   = dwell_eff - DW_ONE;
          sel_d   = 3'd0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = 3'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          cnt_d   = DW_ZERO;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == DW_ZERO) begin
          if (sel_q == 3'd7) begin
            if (cont_q) begin
              sel_d  = 3'd0;
              cnt_d  = dwell_q - DW_ONE;
              wrap_d = 1'b1;
            end else begin
              state_d = IDLE;
              sel_d   = 3'd0;
              cnt_d   = DW_ZERO;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            sel_d = sel_q + 3'd1;
            cnt_d = dwell_q - DW_ONE;
          end
        end else begin
          cnt_d = cnt_q - DW_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
        cnt_d   = DW_ZERO;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign en   = en_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a cycle-index based reference model.
module tb_scan_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          cont;
  logic [DW-1:0] dwell;
  logic          en;
  logic [2:0]    sel;
  logic          busy;
  logic          done;
  logic          wrap;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within a sweep as a plain cycle index
  bit m_busy;
  bit m_cont;
  bit m_done;
  bit m_wrap;
  int m_k;
  int m_d;

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .dwell (dwell),
    .en    (en),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int exp_sel();
    return m_busy ? ((m_k / m_d) % 8) : 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_cont = 1'b0;
    m_done = 1'b0;
    m_wrap = 1'b0;
    m_k    = 0;
    m_d    = 1;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_d    = (dwell == 0) ? 1 : int'(dwell);
        m_cont = cont;
      end
    end else if (stop) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
      if (m_k == 8 * m_d) begin
        m_k = 0;
        if (m_cont) m_wrap = 1'b1;
        else begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".en"},   {31'd0, en},   {31'd0, m_busy});
    check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    check_eq({tag, ".sel"},  {29'd0, sel},  exp_sel());
    check_eq({tag, ".done"}, {31'd0, done}, {31'd0, m_done});
    check_eq({tag, ".wrap"}, {31'd0, wrap}, {31'd0, m_wrap});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic launch(input bit c, input int d, input string tag);
    start = 1'b1;
    cont  = c;
    dwell = DW'(d);
    cycle(tag);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    dwell = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");

    // Start on the very first edge after reset release
    rst_n = 1'b1;
    launch(1'b0, 3, "first_start");
    repeat (30) cycle("oneshot_d3");

    // Continuous dwell 1, then stop at sel 5
    launch(1'b1, 1, "cont_d1");
    repeat (20) cycle("cont_d1");
    for (int i = 0; i < 16 && exp_sel() != 5; i++) cycle("cont_to5");
    stop = 1'b1;
    cycle("stop_at5");
    stop = 1'b0;
    repeat (3) cycle("after_stop");

    launch(1'b0, 0, "oneshot_d0");
    repeat (10) cycle("oneshot_d0");

    start = 1'b1;
    stop  = 1'b1;
    cycle("start_stop");
    start = 1'b0;
    stop  = 1'b0;
    cycle("start_stop_idle");

    // Stop coinciding with the terminal count must suppress wrap
    launch(1'b1, 2, "stop_tc");
    for (int i = 0; i < 40 && !(m_k == 8 * m_d - 1); i++) cycle("run_tc");
    stop = 1'b1;
    cycle("stop_tc");
    stop = 1'b0;
    cycle("stop_tc_idle");

    // Start, dwell and cont changes while scanning are ignored
    launch(1'b0, 2, "ignore");
    repeat (3) cycle("ignore_pre");
    start = 1'b1;
    dwell = DW'(7);
    cont  = 1'b1;
    repeat (4) cycle("ignore_mid");
    start = 1'b0;
    repeat (16) cycle("ignore_post");

    // Asynchronous reset mid-scan at sel 4
    launch(1'b1, 2, "async_rst");
    for (int i = 0; i < 20 && exp_sel() != 4; i++) cycle("run_to4");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("in_reset");
    rst_n = 1'b1;
    launch(1'b0, 1, "post_rst");
    repeat (10) cycle("post_rst");

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      cont  = $urandom_range(0, 1) == 1;
      dwell = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 4));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
